// File: rtl/man_coord_gen.sv
// Raster-order pixel coordinate generator for the Mandelbrot engine.
// Emits one (x, y, idx) tuple per pixel over a valid/ready stream; coordinates are built by accumulation.
module man_coord_gen #(
    parameter int FPW = 54,
    parameter int CW  = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           man_init,
    input  logic [FPW-1:0] man_x0,
    input  logic [FPW-1:0] man_y0,
    input  logic [FPW-1:0] man_xs,
    input  logic [FPW-1:0] man_ys,
    input  logic [CW-1:0]  man_hres,
    input  logic [CW-1:0]  man_vres,
    input  logic [31:0]    man_npixels,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [FPW-1:0] out_x,
    output logic [FPW-1:0] out_y,
    output logic [31:0]    out_idx,
    output logic           man_done,
    output logic [31:0]    man_timer
);

    // state | meaning
    // IDLE  | after reset or abort, waiting for a start edge
    // RUN   | emitting pixel tuples
    // DONE  | frame finished, waiting for a fresh start edge
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic           init_q;
    logic [FPW-1:0] x0_q, x0_d, xs_q, xs_d, ys_q, ys_d;
    logic [CW-1:0]  hres_q, hres_d, vres_q, vres_d;
    logic [31:0]    npix_q, npix_d;
    logic [CW-1:0]  col_q, col_d, row_q, row_d;
    logic [FPW-1:0] x_q, x_d, y_q, y_d;
    logic [31:0]    idx_q, idx_d;
    logic           vld_q, vld_d;
    logic           done_q, done_d;
    logic [31:0]    timer_q, timer_d;

    logic start, degen, xfer, end_col, last;

    always_comb begin
        start   = man_init & ~init_q;
        degen   = (man_hres == '0) | (man_vres == '0) | (man_npixels == '0);
        xfer    = vld_q & out_rdy;
        end_col = (col_q == hres_q - CW'(1));
        // Whichever bound is reached first ends the frame.
        last    = (idx_q == npix_q - 32'd1) | (end_col & (row_q == vres_q - CW'(1)));

        state_d = state_q;
        x0_d    = x0_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        hres_d  = hres_q;
        vres_d  = vres_q;
        npix_d  = npix_q;
        col_d   = col_q;
        row_d   = row_q;
        x_d     = x_q;
        y_d     = y_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        done_d  = done_q;
        timer_d = timer_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    x0_d    = man_x0;
                    xs_d    = man_xs;
                    ys_d    = man_ys;
                    hres_d  = man_hres;
                    vres_d  = man_vres;
                    npix_d  = man_npixels;
                    col_d   = '0;
                    row_d   = '0;
                    x_d     = man_x0;
                    y_d     = man_y0;
                    idx_d   = '0;
                    timer_d = '0;
                    if (degen) begin
                        state_d = DONE;
                        vld_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        vld_d   = 1'b1;
                        done_d  = 1'b0;
                    end
                end
            end
            RUN: begin
                if (!man_init) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                end else begin
                    if (timer_q != 32'hFFFF_FFFF) begin
                        timer_d = timer_q + 32'd1;
                    end
                    if (xfer) begin
                        if (last) begin
                            state_d = DONE;
                            vld_d   = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + 32'd1;
                            if (end_col) begin
                                col_d = '0;
                                row_d = row_q + CW'(1);
                                x_d   = x0_q;
                                y_d   = y_q + ys_q;
                            end else begin
                                col_d = col_q + CW'(1);
                                x_d   = x_q + xs_q;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
            x0_q    <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            hres_q  <= '0;
            vres_q  <= '0;
            npix_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b1;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= man_init;
            x0_q    <= x0_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            hres_q  <= hres_d;
            vres_q  <= vres_d;
            npix_q  <= npix_d;
            col_q   <= col_d;
            row_q   <= row_d;
            x_q     <= x_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            timer_q <= timer_d;
        end
    end

    assign out_vld   = vld_q;
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_idx   = idx_q;
    assign man_done  = done_q;
    assign man_timer = timer_q;

endmodule
